// File: rtl/cdc_cfg_pkg.sv
// Shared types and helpers for the configuration-word CDC arbiter.
// Holds the handshake FSM state encoding and the round-robin pick function.
package cdc_cfg_pkg;

  localparam int unsigned MaxReq = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_e;

  // First set bit at or after ptr, wrapping modulo n; 0 when nothing is set.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (!found && i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing asynchronous levels into clk_i.
// Reset is sampled on the clock edge, so both flops clear synchronously.
module prim_flop_2sync #(
  parameter int unsigned           Width      = 1,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_reg;
  logic [Width-1:0] sync_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_reg <= ResetValue;
      sync_reg <= ResetValue;
    end else begin
      meta_reg <= d_i;
      sync_reg <= meta_reg;
    end
  end

  assign q_o = sync_reg;

endmodule

// File: rtl/cdc_cfg_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel between
// NumReq configuration writers; signals completion back to the winner.
module cdc_cfg_arbiter
  import cdc_cfg_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned IdxWidth  = $clog2(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*DataWidth-1:0] data_i,
  output logic [NumReq-1:0]           done_o,
  output logic                        busy_o,
  output logic                        cdc_req_o,
  output logic [DataWidth-1:0]        cdc_data_o,
  output logic [IdxWidth-1:0]         cdc_idx_o,
  input  logic                        cdc_ack_i
);

  state_e                state_reg, state_next;
  logic [IdxWidth-1:0]   ptr_reg;
  logic [IdxWidth-1:0]   idx_reg;
  logic [DataWidth-1:0]  data_reg;
  logic                  cdc_req_reg;
  logic [NumReq-1:0]     done_reg;
  logic                  ack_s;
  logic [NumReq-1:0]     req_eff;
  logic [NumReq-1:0]     winner_hot;
  logic [IdxWidth-1:0]   pick_idx;
  logic [IdxWidth-1:0]   ptr_after;
  logic                  grant;
  logic                  release_req;
  logic                  finish;
  logic [DataWidth-1:0]  data_arr [NumReq];

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (1'b0)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .d_i    (cdc_ack_i),
    .q_o    (ack_s)
  );

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
    assign data_arr[gi]   = data_i[gi*DataWidth +: DataWidth];
    assign winner_hot[gi] = (idx_reg == IdxWidth'(gi));
  end

  // The finishing requester still holds req_i during its done cycle; mask it
  // so that cycle's arbitration moves on to someone else.
  assign req_eff   = req_i & ~done_reg;
  assign pick_idx  = IdxWidth'(rr_pick(MaxReq'(req_eff), 32'(ptr_reg), NumReq));
  assign ptr_after = (idx_reg == IdxWidth'(NumReq - 1)) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    release_req = 1'b0;
    finish      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|req_eff) begin
          grant      = 1'b1;
          state_next = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          release_req = 1'b1;
          state_next  = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      data_reg    <= '0;
      cdc_req_reg <= 1'b0;
      done_reg    <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= '0;
      if (grant) begin
        data_reg    <= data_arr[pick_idx];
        idx_reg     <= pick_idx;
        cdc_req_reg <= 1'b1;
      end
      if (release_req) cdc_req_reg <= 1'b0;
      if (finish) begin
        done_reg <= winner_hot;
        ptr_reg  <= ptr_after;
      end
    end
  end

  assign busy_o     = (state_reg != IDLE);
  assign cdc_req_o  = cdc_req_reg;
  assign cdc_data_o = data_reg;
  assign cdc_idx_o  = idx_reg;
  assign done_o     = done_reg;

endmodule

// File: tb/tb_cdc_cfg_arbiter.sv
// Directed bench for cdc_cfg_arbiter: reset, single transfer with ack timing,
// pointer wrap, early req drop, mid-transfer reset and round-robin fairness.
module tb_cdc_cfg_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [63:0] data_i;
  logic [3:0]  done_o;
  logic        busy_o;
  logic        cdc_req_o;
  logic [15:0] cdc_data_o;
  logic [1:0]  cdc_idx_o;
  logic        cdc_ack_i;

  int n_cmp = 0;
  int n_mis = 0;

  cdc_cfg_arbiter #(.NumReq(4), .DataWidth(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .cdc_req_o  (cdc_req_o),
    .cdc_data_o (cdc_data_o),
    .cdc_idx_o  (cdc_idx_o),
    .cdc_ack_i  (cdc_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Destination model: wait for req, ack after two cycles, drop ack, wait for done.
  task automatic do_xfer(output logic [1:0] got_idx, output logic [15:0] got_data,
                         output logic [3:0] got_done, output logic ok,
                         output logic data_moved);
    ok = 1'b1;
    data_moved = 1'b0;
    got_done = '0;
    for (int i = 0; i < 20 && cdc_req_o !== 1'b1; i++) tick();
    if (cdc_req_o !== 1'b1) ok = 1'b0;
    got_idx  = cdc_idx_o;
    got_data = cdc_data_o;
    tick();
    tick();
    cdc_ack_i = 1'b1;
    for (int i = 0; i < 20 && cdc_req_o !== 1'b0; i++) begin
      tick();
      if (cdc_data_o !== got_data || cdc_idx_o !== got_idx) data_moved = 1'b1;
    end
    if (cdc_req_o !== 1'b0) ok = 1'b0;
    cdc_ack_i = 1'b0;
    for (int i = 0; i < 20 && done_o === 4'b0000; i++) begin
      tick();
      if (done_o === 4'b0000 && (cdc_data_o !== got_data || cdc_idx_o !== got_idx))
        data_moved = 1'b1;
    end
    if (done_o === 4'b0000) ok = 1'b0;
    got_done = done_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = '0; cdc_ack_i = 1'b0;
    data_i = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A};
    tick(); tick();
    rst_i = 1'b0;
    n_cmp++; if (cdc_req_o !== 1'b0) begin n_mis++; $display("FAIL reset_cdc_req got=%b exp=0", cdc_req_o); end
    n_cmp++; if (cdc_data_o !== 16'h0) begin n_mis++; $display("FAIL reset_cdc_data got=%h exp=0000", cdc_data_o); end
    n_cmp++; if (cdc_idx_o !== 2'd0) begin n_mis++; $display("FAIL reset_cdc_idx got=%0d exp=0", cdc_idx_o); end
    n_cmp++; if (done_o !== 4'b0) begin n_mis++; $display("FAIL reset_done got=%b exp=0000", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    tick();
    n_cmp++; if (cdc_req_o !== 1'b0 || busy_o !== 1'b0) begin n_mis++; $display("FAIL idle_hold req=%b busy=%b exp=0/0", cdc_req_o, busy_o); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    req_i = 4'b0100;
    tick();
    n_cmp++; if (cdc_req_o !== 1'b1) begin n_mis++; $display("FAIL single_req_latency got=%b exp=1", cdc_req_o); end
    n_cmp++; if (cdc_idx_o !== 2'd2) begin n_mis++; $display("FAIL single_idx got=%0d exp=2", cdc_idx_o); end
    n_cmp++; if (cdc_data_o !== 16'hBEEF) begin n_mis++; $display("FAIL single_data got=%h exp=beef", cdc_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    for (int i = 0; i < 4; i++) tick();
    cdc_ack_i = 1'b1;
    tick(); tick();
    n_cmp++; if (cdc_req_o !== 1'b1) begin n_mis++; $display("FAIL ack_rise_t2 got=%b exp=1", cdc_req_o); end
    tick();
    n_cmp++; if (cdc_req_o !== 1'b0) begin n_mis++; $display("FAIL ack_rise_t3 got=%b exp=0", cdc_req_o); end
    n_cmp++; if (cdc_data_o !== 16'hBEEF || cdc_idx_o !== 2'd2) begin n_mis++; $display("FAIL data_frozen_lo data=%h idx=%0d exp=beef/2", cdc_data_o, cdc_idx_o); end
    cdc_ack_i = 1'b0;
    tick(); tick();
    n_cmp++; if (done_o !== 4'b0000) begin n_mis++; $display("FAIL ack_fall_t2 done=%b exp=0000", done_o); end
    tick();
    n_cmp++; if (done_o !== 4'b0100) begin n_mis++; $display("FAIL ack_fall_t3 done=%b exp=0100", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL single_busy_after got=%b exp=0", busy_o); end
    req_i = 4'b0000;
    tick();
    n_cmp++; if (done_o !== 4'b0000 || cdc_req_o !== 1'b0) begin n_mis++; $display("FAIL single_done_width done=%b req=%b exp=0000/0", done_o, cdc_req_o); end
    $display("test_single: done");
  endtask

  task automatic test_ptr_wrap();
    logic [1:0] gi; logic [15:0] gd; logic [3:0] gdn; logic ok; logic mv;
    req_i = 4'b1001;
    do_xfer(gi, gd, gdn, ok, mv);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL wrap_first_timeout ok=%b exp=1", ok); end
    n_cmp++; if (gi !== 2'd3 || gd !== 16'h3333) begin n_mis++; $display("FAIL wrap_first idx=%0d data=%h exp=3/3333", gi, gd); end
    n_cmp++; if (gdn !== 4'b1000) begin n_mis++; $display("FAIL wrap_first_done got=%b exp=1000", gdn); end
    req_i = 4'b0001;
    do_xfer(gi, gd, gdn, ok, mv);
    n_cmp++; if (ok !== 1'b1 || gi !== 2'd0 || gd !== 16'h0A0A || gdn !== 4'b0001) begin
      n_mis++; $display("FAIL wrap_second ok=%b idx=%0d data=%h done=%b exp=1/0/0a0a/0001", ok, gi, gd, gdn);
    end
    req_i = 4'b0000;
    tick();
    $display("test_ptr_wrap: done");
  endtask

  task automatic test_drop_req();
    req_i = 4'b0010;
    data_i[31:16] = 16'h1234;
    tick();
    n_cmp++; if (cdc_req_o !== 1'b1 || cdc_idx_o !== 2'd1 || cdc_data_o !== 16'h1234) begin
      n_mis++; $display("FAIL drop_grant req=%b idx=%0d data=%h exp=1/1/1234", cdc_req_o, cdc_idx_o, cdc_data_o);
    end
    req_i = 4'b0000;
    data_i[31:16] = 16'hFFFF;
    tick();
    cdc_ack_i = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (cdc_req_o !== 1'b0 || cdc_data_o !== 16'h1234) begin
      n_mis++; $display("FAIL drop_release req=%b data=%h exp=0/1234", cdc_req_o, cdc_data_o);
    end
    cdc_ack_i = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (done_o !== 4'b0010) begin n_mis++; $display("FAIL drop_done got=%b exp=0010", done_o); end
    tick();
    $display("test_drop_req: done");
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    req_i = 4'b1000;
    tick();
    n_cmp++; if (cdc_req_o !== 1'b1 || cdc_idx_o !== 2'd3) begin
      n_mis++; $display("FAIL mid_grant req=%b idx=%0d exp=1/3", cdc_req_o, cdc_idx_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 4'b0000;
    n_cmp++; if (cdc_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_mis++; $display("FAIL mid_reset req=%b busy=%b exp=0/0", cdc_req_o, busy_o);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_o !== 4'b0000) saw_done = 1'b1;
      tick();
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_mis++; $display("FAIL mid_no_done saw=%b exp=0", saw_done); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_fairness();
    logic [1:0] gi; logic [15:0] gd; logic [3:0] gdn; logic ok; logic mv;
    logic [1:0] exp_idx;
    logic [15:0] exp_data [4];
    exp_data[0] = 16'hA000; exp_data[1] = 16'hA111; exp_data[2] = 16'hA222; exp_data[3] = 16'hA333;
    data_i = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    req_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_idx = 2'(k % 4);
      do_xfer(gi, gd, gdn, ok, mv);
      n_cmp++;
      if (ok !== 1'b1 || gi !== exp_idx || gd !== exp_data[exp_idx] ||
          gdn !== (4'b0001 << exp_idx) || mv !== 1'b0) begin
        n_mis++;
        $display("FAIL fair_%0d ok=%b idx=%0d data=%h done=%b moved=%b exp idx=%0d data=%h done=%b",
                 k, ok, gi, gd, gdn, mv, exp_idx, exp_data[exp_idx], 4'b0001 << exp_idx);
      end
      $display("fair transfer %0d: idx=%0d data=%h done=%b", k, gi, gd, gdn);
    end
    req_i = 4'b0000;
    tick();
    $display("test_fairness: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_ptr_wrap();
    test_drop_req();
    test_reset_mid();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
